// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: widths, exception codes,
// FSM state encoding and the registered MEM-stage payload.
package ex_mem_stage_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned EXC_CODE_W = 5;

  localparam logic [EXC_CODE_W-1:0] EXC_CODE_NONE = 5'h00;
  localparam logic [EXC_CODE_W-1:0] EXC_CODE_OV   = 5'h0C;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_EXC   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
  } payload_t;

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Conditional branch decision from the ALU zero flag (beq/bne).
// Ports: branch_eq_i, branch_ne_i, zero_i in; taken_c_o combinational out.
module ex_mem_stage_branch_resolve (
  input  logic branch_eq_i,
  input  logic branch_ne_i,
  input  logic zero_i,
  output logic taken_c_o
);

  assign taken_c_o = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);

endmodule

// File: rtl/ex_mem_stage.sv
// Single-entry EX/MEM pipeline stage. Registers the ALU result, control bits
// and branch decision, turns trapping overflow into a held exception, and
// hands the payload to MEM over valid/ready.
// Ports: in_valid/in_ready + EX payload in; out_valid/out_ready + m_* payload
// out; exc_valid/exc_pc/exc_code out with exc_ack in; flush kills FULL/incoming;
// fwd_* forwarding tap, live only when EX_MEM_FWD_EN is defined (else tied 0).
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  trap_ovf,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_AW-1:0]     rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic [DATA_W-1:0]     branch_target,
  input  logic [DATA_W-1:0]     pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     m_result,
  output logic [DATA_W-1:0]     m_store_data,
  output logic [REG_AW-1:0]     m_rd_addr,
  output logic                  m_reg_write,
  output logic                  m_mem_read,
  output logic                  m_mem_write,
  output logic                  m_branch_taken,
  output logic [DATA_W-1:0]     m_branch_target,
  output logic                  exc_valid,
  output logic [DATA_W-1:0]     exc_pc,
  output logic [EXC_CODE_W-1:0] exc_code,
  input  logic                  exc_ack,
  output logic                  fwd_valid,
  output logic [REG_AW-1:0]     fwd_addr,
  output logic [DATA_W-1:0]     fwd_data
);

  state_e                  state_q, state_d;
  payload_t                pay_q, pay_d;
  logic [DATA_W-1:0]       exc_pc_q, exc_pc_d;
  logic [EXC_CODE_W-1:0]   exc_code_q, exc_code_d;
  logic                    taken_c;
  logic                    in_ready_c;
  logic                    accept_c;
  logic                    trap_c;

  ex_mem_stage_branch_resolve u_branch_resolve (
    .branch_eq_i (branch_eq),
    .branch_ne_i (branch_ne),
    .zero_i      (alu_zero),
    .taken_c_o   (taken_c)
  );

  // Ready is held low while reset is asserted so every output reads 0.
  assign in_ready_c = rst_n & ((state_q == ST_EMPTY) | ((state_q == ST_FULL) & out_ready));
  assign accept_c   = in_valid & in_ready_c & ~flush;
  assign trap_c     = alu_overflow & trap_ovf;

  // State register and payload/exception registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      pay_q      <= '0;
      exc_pc_q   <= '0;
      exc_code_q <= EXC_CODE_NONE;
    end else begin
      state_q    <= state_d;
      pay_q      <= pay_d;
      exc_pc_q   <= exc_pc_d;
      exc_code_q <= exc_code_d;
    end
  end

  // Next-state, payload capture and exception capture.
  always_comb begin
    state_d    = state_q;
    pay_d      = pay_q;
    exc_pc_d   = exc_pc_q;
    exc_code_d = exc_code_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept_c) state_d = trap_c ? ST_EXC : ST_FULL;
      end
      ST_FULL: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (out_ready) begin
          if (accept_c) state_d = trap_c ? ST_EXC : ST_FULL;
          else          state_d = ST_EMPTY;
        end
      end
      ST_EXC: begin
        if (exc_ack) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (accept_c && !trap_c) begin
      pay_d.result        = alu_result;
      pay_d.store_data    = store_data;
      pay_d.rd_addr       = rd_addr;
      pay_d.reg_write     = reg_write & (rd_addr != '0);
      pay_d.mem_read      = mem_read;
      pay_d.mem_write     = mem_write;
      pay_d.branch_taken  = taken_c;
      pay_d.branch_target = branch_target;
    end

    if (accept_c && trap_c) begin
      exc_pc_d   = pc;
      exc_code_d = EXC_CODE_OV;
    end else if ((state_q == ST_EXC) && (state_d == ST_EMPTY)) begin
      exc_pc_d   = '0;
      exc_code_d = EXC_CODE_NONE;
    end

    // Side-effect bits must never survive outside FULL.
    if (state_d != ST_FULL) begin
      pay_d.reg_write    = 1'b0;
      pay_d.mem_read     = 1'b0;
      pay_d.mem_write    = 1'b0;
      pay_d.branch_taken = 1'b0;
    end
  end

  assign in_ready        = in_ready_c;
  assign out_valid       = (state_q == ST_FULL);
  assign exc_valid       = (state_q == ST_EXC);
  assign exc_pc          = exc_pc_q;
  assign exc_code        = exc_code_q;
  assign m_result        = pay_q.result;
  assign m_store_data    = pay_q.store_data;
  assign m_rd_addr       = pay_q.rd_addr;
  assign m_reg_write     = pay_q.reg_write;
  assign m_mem_read      = pay_q.mem_read;
  assign m_mem_write     = pay_q.mem_write;
  assign m_branch_taken  = pay_q.branch_taken;
  assign m_branch_target = pay_q.branch_target;

`ifdef EX_MEM_FWD_EN
  // Loads are excluded: their data is not known until MEM.
  assign fwd_valid = (state_q == ST_FULL) & pay_q.reg_write & ~pay_q.mem_read;
  assign fwd_addr  = pay_q.rd_addr;
  assign fwd_data  = pay_q.result;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed checks plus a scoreboard of
// accepted payloads compared on each MEM handshake.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow, trap_ovf;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_read, mem_write, branch_eq, branch_ne;
  logic [31:0] branch_target, pc;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] m_result, m_store_data;
  logic [4:0]  m_rd_addr;
  logic        m_reg_write, m_mem_read, m_mem_write, m_branch_taken;
  logic [31:0] m_branch_target;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic [4:0]  exc_code;
  logic        exc_ack;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  typedef struct {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [31:0] target;
    logic [8:0]  ctrl; // {rd, reg_write, mem_read, mem_write, taken}
  } item_t;

  item_t sb_q[$];
  item_t exp_item;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .trap_ovf(trap_ovf), .store_data(store_data), .rd_addr(rd_addr),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .branch_target(branch_target),
    .pc(pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .m_result(m_result), .m_store_data(m_store_data), .m_rd_addr(m_rd_addr),
    .m_reg_write(m_reg_write), .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
    .m_branch_taken(m_branch_taken), .m_branch_target(m_branch_target),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_code(exc_code), .exc_ack(exc_ack),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference payload for the current EX inputs.
  function automatic item_t mk_item();
    item_t it;
    it.result     = alu_result;
    it.store_data = store_data;
    it.target     = branch_target;
    it.ctrl       = {rd_addr, reg_write && (rd_addr != 5'd0), mem_read, mem_write,
                     (branch_eq && alu_zero) || (branch_ne && !alu_zero)};
    return it;
  endfunction

  // Scoreboard: sample mid-cycle, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && (out_ready || flush)) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_item = sb_q.pop_front();
          if (!flush) begin
            check("sb_result", {32'd0, m_result}, {32'd0, exp_item.result});
            check("sb_store",  {32'd0, m_store_data}, {32'd0, exp_item.store_data});
            check("sb_target", {32'd0, m_branch_target}, {32'd0, exp_item.target});
            check("sb_ctrl",   {55'd0, m_rd_addr, m_reg_write, m_mem_read, m_mem_write, m_branch_taken},
                               {55'd0, exp_item.ctrl});
          end
        end
      end
      if (in_valid && in_ready && !flush && !(alu_overflow && trap_ovf))
        sb_q.push_back(mk_item());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; alu_result = 0; alu_zero = 0; alu_overflow = 0; trap_ovf = 0;
    store_data = 0; rd_addr = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    branch_eq = 0; branch_ne = 0; branch_target = 0; pc = 0; flush = 0;
  endtask

  task automatic op(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                    input logic beq, input logic bne, input logic zero,
                    input logic ovf, input logic trap,
                    input logic [31:0] tgt, input logic [31:0] pcv);
    idle();
    in_valid = 1; alu_result = res; store_data = ~res; rd_addr = rd; reg_write = rw;
    branch_eq = beq; branch_ne = bne; alu_zero = zero; alu_overflow = ovf;
    trap_ovf = trap; branch_target = tgt; pc = pcv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    exc_ack = 0; out_ready = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd0);
    check("rst_exc_valid", {63'd0, exc_valid}, 64'd0);
    check("rst_m_result",  {32'd0, m_result}, 64'd0);
    rst_n = 1;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // beq taken, then bne back-to-back (not taken)
    out_ready = 1;
    op(32'h0, 5'd0, 0, 1, 0, 1, 0, 0, 32'h0040_0020, 32'h0040_0000);
    tick();
    check("beq_valid",  {63'd0, out_valid}, 64'd1);
    check("beq_taken",  {63'd0, m_branch_taken}, 64'd1);
    check("beq_target", {32'd0, m_branch_target}, 64'h0040_0020);
    op(32'h0, 5'd0, 0, 0, 1, 1, 0, 0, 32'h0040_0040, 32'h0040_0004);
    tick();
    check("bne_valid", {63'd0, out_valid}, 64'd1);
    check("bne_taken", {63'd0, m_branch_taken}, 64'd0);
    idle();
    tick();
    check("empty_valid", {63'd0, out_valid}, 64'd0);
    check("empty_taken", {63'd0, m_branch_taken}, 64'd0);

    // trapping overflow
    op(32'h8000_0000, 5'd3, 1, 0, 0, 0, 1, 1, 32'h0, 32'h0040_0010);
    tick();
    check("exc_valid",    {63'd0, exc_valid}, 64'd1);
    check("exc_pc",       {32'd0, exc_pc}, 64'h0040_0010);
    check("exc_code",     {59'd0, exc_code}, 64'h0C);
    check("exc_out_valid",{63'd0, out_valid}, 64'd0);
    check("exc_in_ready", {63'd0, in_ready}, 64'd0);
    check("exc_reg_write",{63'd0, m_reg_write}, 64'd0);
    idle();
    flush = 1;
    tick();
    check("exc_flush_hold", {63'd0, exc_valid}, 64'd1);
    check("exc_flush_pc",   {32'd0, exc_pc}, 64'h0040_0010);
    flush = 0; exc_ack = 1;
    tick();
    exc_ack = 0;
    check("ack_exc_valid", {63'd0, exc_valid}, 64'd0);
    check("ack_in_ready",  {63'd0, in_ready}, 64'd1);
    check("ack_exc_code",  {59'd0, exc_code}, 64'd0);

    // non-trapping overflow passes through
    op(32'h8000_0000, 5'd3, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0040_0014);
    tick();
    check("addu_valid",  {63'd0, out_valid}, 64'd1);
    check("addu_exc",    {63'd0, exc_valid}, 64'd0);
    check("addu_result", {32'd0, m_result}, 64'h8000_0000);
    check("addu_rw",     {63'd0, m_reg_write}, 64'd1);
    idle();
    tick();

    // back-to-back with MEM stall
    out_ready = 0;
    op(32'h11, 5'd1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h100);
    tick();
    op(32'h22, 5'd2, 1, 0, 0, 0, 0, 0, 32'h0, 32'h104);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_result",   {32'd0, m_result}, 64'h11);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1;
    tick();
    check("b2b_22",       {32'd0, m_result}, 64'h22);
    check("b2b_22_valid", {63'd0, out_valid}, 64'd1);
    op(32'h33, 5'd4, 1, 0, 0, 0, 0, 0, 32'h0, 32'h108);
    tick();
    check("b2b_33",       {32'd0, m_result}, 64'h33);
    check("b2b_33_valid", {63'd0, out_valid}, 64'd1);
    idle();
    tick();
    check("b2b_drain", {63'd0, out_valid}, 64'd0);

    // r0 write suppression and forwarding tap
    op(32'hDEAD_BEEF, 5'd0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h200);
    tick();
    check("r0_rw",  {63'd0, m_reg_write}, 64'd0);
    check("r0_fwd", {63'd0, fwd_valid}, 64'd0);
    op(32'h1234, 5'd5, 1, 0, 0, 0, 0, 0, 32'h0, 32'h204);
    tick();
    check("r5_rw", {63'd0, m_reg_write}, 64'd1);
`ifdef EX_MEM_FWD_EN
    check("fwd_valid", {63'd0, fwd_valid}, 64'd1);
    check("fwd_addr",  {59'd0, fwd_addr}, 64'd5);
    check("fwd_data",  {32'd0, fwd_data}, 64'h1234);
`else
    check("fwd_off_valid", {63'd0, fwd_valid}, 64'd0);
    check("fwd_off_data",  {32'd0, fwd_data}, 64'd0);
`endif
    op(32'h5678, 5'd6, 1, 0, 0, 0, 0, 0, 32'h0, 32'h208);
    mem_read = 1;
    tick();
    check("load_mr",  {63'd0, m_mem_read}, 64'd1);
    check("load_fwd", {63'd0, fwd_valid}, 64'd0);
    idle();
    tick();

    // flush while FULL with incoming payload
    out_ready = 0;
    op(32'hAA, 5'd7, 1, 0, 0, 0, 0, 0, 32'h0, 32'h300);
    tick();
    check("pre_flush_valid", {63'd0, out_valid}, 64'd1);
    op(32'hBB, 5'd8, 1, 0, 0, 0, 0, 0, 32'h0, 32'h304);
    flush = 1;
    tick();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_rw",    {63'd0, m_reg_write}, 64'd0);
    idle();
    tick();
    check("flush_no_bb", {63'd0, out_valid}, 64'd0);
    out_ready = 1;

    // async reset during EXC
    op(32'h0, 5'd9, 1, 0, 0, 0, 1, 1, 32'h0, 32'h0040_0030);
    tick();
    check("exc2_valid", {63'd0, exc_valid}, 64'd1);
    idle();
    #2 rst_n = 0;
    #1;
    check("arst_exc_valid", {63'd0, exc_valid}, 64'd0);
    check("arst_exc_pc",    {32'd0, exc_pc}, 64'd0);
    check("arst_exc_code",  {59'd0, exc_code}, 64'd0);
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, in_ready}, 64'd0);
    check("arst_m_result",  {32'd0, m_result}, 64'd0);
    tick();
    rst_n = 1;
    #1;
    check("rel_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rel_exc_valid", {63'd0, exc_valid}, 64'd0);
    op(32'h55, 5'd10, 1, 0, 0, 0, 0, 0, 32'h0, 32'h400);
    tick();
    check("rel_result", {32'd0, m_result}, 64'h55);
    idle();
    tick();
    tick();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Single-entry EX/MEM pipeline stage directly downstream of the execute-stage ALU.
- Captures the ALU result and flags plus control bits, and resolves conditional branches from the zero flag.
- Converts signed-add/sub overflow into a held exception request.
- Presents a registered payload to the memory stage over a valid/ready handshake.

Parameters:
DATA_W, 32, datapath width (result, store data, PC, branch target)
REG_AW, 5, register-file address width
EXC_CODE_OV, 5'h0C, exception code reported for arithmetic overflow

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX payload valid
in_ready  out  1  stage can accept EX payload
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU signed overflow flag
trap_ovf  in  1  instruction traps on overflow (add/sub; 0 for addu/subu)
store_data  in  DATA_W  rt value for stores
rd_addr  in  REG_AW  destination register
reg_write  in  1  writes register file
mem_read  in  1  load
mem_write  in  1  store
branch_eq  in  1  beq
branch_ne  in  1  bne
branch_target  in  DATA_W  computed branch target
pc  in  DATA_W  instruction PC
flush  in  1  synchronous kill of held/incoming payload
out_valid  out  1  MEM payload valid
out_ready  in  1  MEM stage accepts payload
m_result, m_store_data, m_rd_addr, m_reg_write, m_mem_read, m_mem_write  out  as inputs  registered payload
m_branch_taken  out  1  registered branch decision
m_branch_target  out  DATA_W  registered target
exc_valid  out  1  overflow exception pending
exc_pc  out  DATA_W  PC of faulting instruction
exc_code  out  5  exception code
exc_ack  in  1  exception consumed
fwd_valid, fwd_addr, fwd_data  out  1/REG_AW/DATA_W  forwarding tap (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state EMPTY; every output and payload register 0.
- States:
  - EMPTY: in_ready=1, out_valid=0.
  - FULL: out_valid=1, in_ready=out_ready.
  - EXC: in_ready=0, out_valid=0, exc_valid=1.
- Accept = in_valid & in_ready & ~flush. On accept with ~(alu_overflow & trap_ovf): payload registered, state -> FULL, latency 1 cycle.
- On accept with alu_overflow & trap_ovf: state -> EXC. Payload is not presented. exc_pc<=pc, exc_code<=EXC_CODE_OV; both held until exit.
- FULL & out_ready & ~accept -> EMPTY. FULL & out_ready & accept -> FULL with new payload; out_valid stays 1 (no bubble).
- FULL & ~out_ready: payload and outputs stable.
- EXC & exc_ack -> EMPTY. exc_valid deasserts the cycle after ack; earliest ack is the cycle after exc_valid rises.
- flush: FULL -> EMPTY and incoming payload dropped. flush beats accept in the same cycle. flush does not affect EXC.
- Payload rules:
  - m_reg_write <= reg_write & (rd_addr != 0).
  - m_branch_taken <= (branch_eq & alu_zero) | (branch_ne & ~alu_zero).
  - Branch is meaningful only while out_valid. The MEM stage redirects once, on the out_valid & out_ready handshake.
- In EMPTY and EXC, m_reg_write, m_mem_read, m_mem_write and m_branch_taken read 0. No side effect may leak from a squashed or faulting instruction.
- Reset mid-operation: immediate return to EMPTY; a pending exception is lost.

Optional Feature:
- Macro EX_MEM_FWD_EN.
- Defined:
  - fwd_valid = out_valid & m_reg_write & ~m_mem_read.
  - fwd_addr = m_rd_addr.
  - fwd_data = m_result.
  - All three are combinational from registers, for EX-stage operand bypass.
- Undefined: fwd_valid, fwd_addr and fwd_data are tied to 0. Ports remain present.

Decomposition:
- Shared package holds:
  - the state encoding typedef (EMPTY/FULL/EXC);
  - EXC_CODE_OV and other exception-code constants;
  - the width constants DATA_W and REG_AW.
- One natural sub-module, branch_resolve: a combinational taken decision from branch_eq/branch_ne/zero, reusable by a later early-branch stage.

Test Plan:
- Reset then beq with alu_zero=1, branch_target=0x0040_0020, out_ready=1 -> next cycle out_valid=1, m_branch_taken=1, m_branch_target=0x0040_0020. Same with bne -> m_branch_taken=0.
- add with alu_overflow=1, trap_ovf=1, pc=0x0040_0010 -> next cycle exc_valid=1, exc_pc=0x0040_0010, exc_code=0x0C, out_valid=0, in_ready=0. exc_ack one cycle later -> EMPTY. Repeat with trap_ovf=0 -> normal FULL, m_result passes through.
- Back-to-back inputs 0x11, 0x22, 0x33 with out_ready low for 3 cycles after the first -> m_result holds 0x11. Then 0x22 and 0x33 appear with no loss or duplication and no bubble.
- reg_write=1, rd_addr=0, alu_result=0xDEAD_BEEF -> m_reg_write=0. Under EX_MEM_FWD_EN, fwd_valid=0.
- flush asserted while FULL and in_valid=1 in the same cycle -> next cycle out_valid=0; the incoming payload never appears.
- rst_n pulsed low mid-EXC -> exc_valid=0 and all outputs 0 immediately (asynchronous); in_ready=1 after release.
